// File: rtl/async_fifo_rd_packer_if.sv
// Handshake bundle between the read-side packer, the FIFO read port and the downstream word stream.
// master = packer side, slave = FIFO/downstream side.
interface async_fifo_rd_packer_if #(
    parameter int DWIDTH   = 8,
    parameter int PACK     = 4,
    parameter int CNTWIDTH = 16
);
    logic                     enable;
    logic                     empty;
    logic [DWIDTH-1:0]        rdata;
    logic                     pop;
    logic                     out_valid;
    logic [PACK*DWIDTH-1:0]   out_data;
    logic                     out_ready;
    logic [CNTWIDTH-1:0]      word_cnt;

    modport master (
        input  enable, empty, rdata, out_ready,
        output pop, out_valid, out_data, word_cnt
    );

    modport slave (
        output enable, empty, rdata, out_ready,
        input  pop, out_valid, out_data, word_cnt
    );
endinterface

// File: rtl/async_fifo_rd_packer.sv
// Pops PACK bytes from the FIFO read port and presents them as one little-endian word; last pop to out_valid is 3 cycles.
// Back-pressure: at most one finished word waits in HOLD while out_valid&~out_ready, with pop held low.
module async_fifo_rd_packer #(
    parameter int DWIDTH   = 8,
    parameter int PACK     = 4,
    parameter int CNTWIDTH = 16
) (
    input  logic                   rclk,
    input  logic                   reset,
    async_fifo_rd_packer_if.master bus
);
    localparam int AW = $clog2(PACK + 1);
    localparam int LW = $clog2(PACK);
    localparam logic [AW-1:0] FULL = AW'(PACK);

    typedef enum logic [1:0] {PH_FILL, PH_LAST, PH_HOLD} phase_t;

    logic [AW-1:0]                acnt_q, acnt_d;
    logic                         inflight_q, inflight_d;
    logic [PACK-1:0][DWIDTH-1:0]  asm_q, asm_d;
    logic [PACK*DWIDTH-1:0]       out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic [CNTWIDTH-1:0]          word_cnt_q, word_cnt_d;

    phase_t         phase;
    logic           xfer;
    logic           pop;
    logic           accept;
    logic [LW-1:0]  lane;

    always_comb begin
        phase = PH_FILL;
        if (acnt_q == FULL) begin
            phase = inflight_q ? PH_LAST : PH_HOLD;
        end
    end

    assign accept = out_valid_q & bus.out_ready;
    assign xfer   = (phase == PH_HOLD) & (~out_valid_q | bus.out_ready);
    assign pop    = bus.enable & ~bus.empty & ((phase == PH_FILL) | xfer);
    // acnt already counts the in-flight byte, so its lane is one below.
    assign lane   = LW'(acnt_q - AW'(1));

    always_comb begin
        acnt_d      = acnt_q;
        inflight_d  = pop;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        if (inflight_q) begin
            asm_d[lane] = bus.rdata;
        end

        if (xfer) begin
            acnt_d      = pop ? AW'(1) : '0;
            out_data_d  = asm_q;
            out_valid_d = 1'b1;
        end else begin
            if (pop) begin
                acnt_d = acnt_q + AW'(1);
            end
            if (accept) begin
                out_valid_d = 1'b0;
            end
        end

        if (accept) begin
            word_cnt_d = word_cnt_q + CNTWIDTH'(1);
        end
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            acnt_q      <= '0;
            inflight_q  <= 1'b0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            acnt_q      <= acnt_d;
            inflight_q  <= inflight_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.pop       = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Directed bench: a queue models the FIFO, expected words go into a scoreboard that a monitor drains on each accept.
`timescale 1ns/1ps
module tb_async_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = 4;

    logic rclk = 1'b0;
    logic reset;
    always #5 rclk = ~rclk;

    async_fifo_rd_packer_if #(.DWIDTH(DW), .PACK(PK), .CNTWIDTH(CW)) bus ();

    async_fifo_rd_packer #(.DWIDTH(DW), .PACK(PK), .CNTWIDTH(CW)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  fifo_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  next_rdata = 8'hEE;
    logic        en_r = 1'b0;
    logic        rdy_r = 1'b0;
    logic        force_empty = 1'b0;
    int          pop_cnt = 0;
    logic [CW-1:0] prev_cnt = '0;
    logic        wrap_seen = 1'b0;
    logic [8:0]  pop_hist = '0;
    int          hist_n = 0;
    logic        hist_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One rclk cycle: drive inputs at the falling edge, then sample and advance the FIFO model.
    task automatic step();
        @(negedge rclk);
        bus.rdata     = next_rdata;
        next_rdata    = 8'hEE;
        bus.enable    = en_r;
        bus.out_ready = rdy_r;
        bus.empty     = reset | force_empty | (fifo_q.size() == 0);
        #1;
        if (bus.empty) check("pop_while_empty", bus.pop, 0);
        if (bus.pop && !reset) begin
            next_rdata = fifo_q.pop_front();
            pop_cnt++;
        end
        if (hist_on && (hist_n > 0 || bus.pop) && hist_n < 9) begin
            pop_hist = {pop_hist[7:0], bus.pop};
            hist_n++;
        end
        if (!reset && bus.word_cnt != prev_cnt) begin
            if (prev_cnt == 4'hF && bus.word_cnt == 4'h0) wrap_seen = 1'b1;
            prev_cnt = bus.word_cnt;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_q.delete();
        next_rdata  = 8'hEE;
        en_r        = 1'b0;
        rdy_r       = 1'b0;
        force_empty = 1'b0;
        step();
        step();
        reset    = 1'b0;
        prev_cnt = '0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic load(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) fifo_q.push_back(first + 8'(i));
    endtask

    initial begin : monitor
        forever begin
            @(negedge rclk);
            #2;
            if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got 0x%0h, want no word", bus.out_data);
                end else begin
                    check("word", bus.out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        bus.enable    = 1'b0;
        bus.empty     = 1'b1;
        bus.rdata     = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        step();
        step();
        check("rst_pop", bus.pop, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_word_cnt", bus.word_cnt, 0);
        reset = 1'b0;

        // Basic packing and the one-bubble pop rhythm.
        load(8'h01, 8);
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        en_r = 1'b1; rdy_r = 1'b1; hist_on = 1'b1;
        drain(40, "t1");
        check("t1_pop_pattern", pop_hist, 9'b111101111);
        check("t1_word_cnt", bus.word_cnt, 2);
        hist_on = 1'b0;

        // Back-pressure: one word on the output, one parked in HOLD.
        do_reset();
        load(8'h10, 12);
        exp_q.push_back(32'h13121110);
        exp_q.push_back(32'h17161514);
        exp_q.push_back(32'h1B1A1918);
        en_r = 1'b1; rdy_r = 1'b0;
        repeat (20) step();
        check("t2_held_valid", bus.out_valid, 1);
        check("t2_held_data", bus.out_data, 32'h13121110);
        check("t2_fifo_left", fifo_q.size(), 4);
        pop_cnt = 0;
        repeat (5) step();
        check("t2_no_pop_stalled", pop_cnt, 0);
        rdy_r = 1'b1;
        drain(60, "t2");
        check("t2_word_cnt", bus.word_cnt, 3);

        // Empty flag toggling every two cycles.
        do_reset();
        load(8'h0A, 8);
        exp_q.push_back(32'h0D0C0B0A);
        exp_q.push_back(32'h11100F0E);
        en_r = 1'b1; rdy_r = 1'b1;
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            force_empty = ((i / 2) % 2) == 1;
            step();
        end
        force_empty = 1'b0;
        drain(10, "t3");
        check("t3_word_cnt", bus.word_cnt, 2);

        // Enable dropped after two pops, held low for ten cycles.
        do_reset();
        load(8'h21, 8);
        exp_q.push_back(32'h24232221);
        exp_q.push_back(32'h28272625);
        en_r = 1'b1; rdy_r = 1'b1; pop_cnt = 0;
        for (int i = 0; i < 10 && pop_cnt < 2; i++) step();
        check("t4_pops_before_gap", pop_cnt, 2);
        en_r = 1'b0; pop_cnt = 0;
        repeat (10) step();
        check("t4_no_pop_gap", pop_cnt, 0);
        check("t4_no_word_in_gap", bus.out_valid, 0);
        en_r = 1'b1;
        drain(40, "t4");
        check("t4_word_cnt", bus.word_cnt, 2);

        // Asynchronous reset with out_valid set and a byte in flight.
        do_reset();
        load(8'h31, 12);
        exp_q.push_back(32'h34333231);
        en_r = 1'b1; rdy_r = 1'b1;
        for (int i = 0; i < 20 && bus.word_cnt != 1; i++) step();
        check("t5_first_word_cnt", bus.word_cnt, 1);
        rdy_r = 1'b0;
        for (int i = 0; i < 20 && !(bus.out_valid && bus.pop); i++) step();
        check("t5_valid_and_pop", {bus.out_valid, bus.pop}, 2'b11);
        @(posedge rclk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_out_valid", bus.out_valid, 0);
        check("t5_rst_out_data", bus.out_data, 0);
        check("t5_rst_word_cnt", bus.word_cnt, 0);
        fifo_q.delete();
        next_rdata = 8'hEE;
        step();
        step();
        reset = 1'b0;
        prev_cnt = '0;
        load(8'h41, 4);
        exp_q.push_back(32'h44434241);
        rdy_r = 1'b1;
        drain(30, "t5");
        check("t5_word_cnt", bus.word_cnt, 1);

        // Counter wrap: 17 words through a 4-bit counter.
        do_reset();
        wrap_seen = 1'b0;
        for (int w = 0; w < 17; w++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'h50 + 8'(4 * w);
            b1 = b0 + 8'd1;
            b2 = b0 + 8'd2;
            b3 = b0 + 8'd3;
            fifo_q.push_back(b0);
            fifo_q.push_back(b1);
            fifo_q.push_back(b2);
            fifo_q.push_back(b3);
            exp_q.push_back({b3, b2, b1, b0});
        end
        en_r = 1'b1; rdy_r = 1'b1;
        drain(300, "t6");
        check("t6_word_cnt_wrapped", bus.word_cnt, 1);
        check("t6_wrap_seen", wrap_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
